// File: rtl/bridge_pkg.sv
// Shared definitions for the AHB-to-APB bridge: FSM state encoding, HTRANS codes and
// the APB slave address map shared with the AHB slave interface.
package bridge_pkg;

    localparam int unsigned ST_W     = 3;
    localparam int unsigned HTRANS_W = 2;
    localparam int unsigned MAP_W    = 32;

    typedef enum logic [ST_W-1:0] {
        ST_IDLE     = 3'd0,
        ST_READ     = 3'd1,
        ST_RENABLE  = 3'd2,
        ST_WWAIT    = 3'd3,
        ST_WRITE    = 3'd4,
        ST_WRITEP   = 3'd5,
        ST_WENABLE  = 3'd6,
        ST_WENABLEP = 3'd7
    } state_e;

    localparam logic [HTRANS_W-1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [HTRANS_W-1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [HTRANS_W-1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [HTRANS_W-1:0] HTRANS_SEQ    = 2'b11;

    // Slave windows: [base, base + 0x0400_0000) each
    localparam logic [MAP_W-1:0] SLV0_BASE = 32'h8000_0000;
    localparam logic [MAP_W-1:0] SLV1_BASE = 32'h8400_0000;
    localparam logic [MAP_W-1:0] SLV2_BASE = 32'h8800_0000;
    localparam logic [MAP_W-1:0] MAP_TOP   = 32'h8C00_0000;

endpackage

// File: rtl/apb_fsm_controller.sv
// APB side of the AHB-to-APB bridge: turns pipelined AHB transfers into APB
// setup/enable phases and stalls the AHB master through Hreadyout.
module apb_fsm_controller
    import bridge_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned NSLV   = 3
) (
    input  logic              Hclk,
    input  logic              Hreset,
    input  logic              valid,
    input  logic              Hwrite,
    input  logic              Hwritereg,
    input  logic [ADDR_W-1:0] Haddr1,
    input  logic [ADDR_W-1:0] Haddr2,
    input  logic [DATA_W-1:0] Hwdata1,
    input  logic [DATA_W-1:0] Hwdata2,
    input  logic [NSLV-1:0]   tempselx,
    input  logic [DATA_W-1:0] Prdata,
    output logic [NSLV-1:0]   Pselx,
    output logic              Penable,
    output logic              Pwrite,
    output logic [ADDR_W-1:0] Paddr,
    output logic [DATA_W-1:0] Pwdata,
    output logic              Hreadyout,
    output logic [DATA_W-1:0] Hrdata
);

    state_e state;
    state_e next_state;

    // Read data goes straight back to the AHB side
    assign Hrdata = Prdata;

    always_ff @(posedge Hclk) begin
        if (Hreset) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE, ST_RENABLE, ST_WENABLE: begin
                if (!valid) begin
                    next_state = ST_IDLE;
                end else if (Hwrite) begin
                    next_state = ST_WWAIT;
                end else begin
                    next_state = ST_READ;
                end
            end
            ST_READ:   next_state = ST_RENABLE;
            ST_WWAIT:  next_state = valid ? ST_WRITEP : ST_WRITE;
            ST_WRITE:  next_state = valid ? ST_WENABLEP : ST_WENABLE;
            ST_WRITEP: next_state = ST_WENABLEP;
            ST_WENABLEP: begin
                if (!Hwritereg) begin
                    next_state = ST_READ;
                end else if (valid) begin
                    next_state = ST_WRITEP;
                end else begin
                    next_state = ST_WRITE;
                end
            end
            default:   next_state = ST_IDLE;
        endcase
    end

    // Outputs are decoded from next_state so they land on the edge the state is entered
    always_ff @(posedge Hclk) begin
        if (Hreset) begin
            Pselx     <= '0;
            Penable   <= 1'b0;
            Pwrite    <= 1'b0;
            Paddr     <= '0;
            Pwdata    <= '0;
            Hreadyout <= 1'b1;
        end else begin
            case (next_state)
                ST_IDLE, ST_WWAIT: begin
                    Pselx     <= '0;
                    Penable   <= 1'b0;
                    Hreadyout <= 1'b1;
                end
                ST_READ: begin
                    Pselx     <= tempselx;
                    Paddr     <= Haddr1;
                    Pwrite    <= 1'b0;
                    Penable   <= 1'b0;
                    Hreadyout <= 1'b0;
                end
                ST_WRITE: begin
                    Pselx     <= tempselx;
                    Paddr     <= Haddr1;
                    Pwdata    <= Hwdata1;
                    Pwrite    <= 1'b1;
                    Penable   <= 1'b0;
                    Hreadyout <= 1'b1;
                end
                ST_WRITEP: begin
                    Pselx     <= tempselx;
                    Paddr     <= Haddr2;
                    Pwdata    <= Hwdata2;
                    Pwrite    <= 1'b1;
                    Penable   <= 1'b0;
                    Hreadyout <= 1'b0;
                end
                default: begin
                    Penable   <= 1'b1;
                    Hreadyout <= 1'b1;
                end
            endcase
        end
    end

endmodule
